// File: rtl/cw305_reg_bus_master.sv
`default_nettype none
// ============================================================================
// cw305_reg_bus_master : command + byte-stream initiator for the CW305
//                        byte-serial register bus (usb_clk domain).
// Revision: 1.0
// ============================================================================
module cw305_reg_bus_master #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 8
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_i,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] cmd_addr,
    input  logic [pBYTECNT_SIZE-1:0]             cmd_last,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [7:0]                           wr_data,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic [7:0]                           rd_data,
    input  logic                                 abort_i,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 aborted,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           write_data,
    input  logic [7:0]                           read_data,
    output logic                                 reg_read,
    output logic                                 reg_write,
    output logic                                 reg_addrvalid
);

    localparam int BW = pBYTECNT_SIZE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        WR_WAIT   = 3'd2,
        WR_STROBE = 3'd3,
        RD_STROBE = 3'd4,
        RD_CAPT   = 3'd5,
        RD_HOLD   = 3'd6,
        FINISH    = 3'd7
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   last_q;
    logic            write_q;

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WR_WAIT);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            last_q        <= '0;
            write_q       <= 1'b0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            write_data    <= '0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_addrvalid <= 1'b0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            // Abort outranks any handshake seen in the same cycle.
            if (abort_i && (state_q != IDLE)) begin
                reg_read      <= 1'b0;
                reg_write     <= 1'b0;
                reg_addrvalid <= 1'b0;
                rd_valid      <= 1'b0;
                done          <= 1'b1;
                aborted       <= 1'b1;
                state_q       <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_valid) begin
                            reg_address   <= cmd_addr;
                            last_q        <= cmd_last;
                            write_q       <= cmd_write;
                            reg_addrvalid <= 1'b1;
                            reg_bytecnt   <= '0;
                            state_q       <= SETUP;
                        end
                    end
                    SETUP: begin
                        if (write_q) begin
                            state_q <= WR_WAIT;
                        end else begin
                            reg_read <= 1'b1;
                            state_q  <= RD_STROBE;
                        end
                    end
                    WR_WAIT: begin
                        if (wr_valid) begin
                            write_data <= wr_data;
                            reg_write  <= 1'b1;
                            state_q    <= WR_STROBE;
                        end
                    end
                    WR_STROBE: begin
                        reg_write <= 1'b0;
                        if (reg_bytecnt == last_q) begin
                            state_q <= FINISH;
                        end else begin
                            reg_bytecnt <= reg_bytecnt + BW'(1);
                            state_q     <= WR_WAIT;
                        end
                    end
                    RD_STROBE: begin
                        reg_read <= 1'b0;
                        state_q  <= RD_CAPT;
                    end
                    // Slave data is valid the cycle after the read strobe.
                    RD_CAPT: begin
                        rd_data  <= read_data;
                        rd_valid <= 1'b1;
                        state_q  <= RD_HOLD;
                    end
                    RD_HOLD: begin
                        if (rd_ready) begin
                            rd_valid <= 1'b0;
                            if (reg_bytecnt == last_q) begin
                                state_q <= FINISH;
                            end else begin
                                reg_bytecnt <= reg_bytecnt + BW'(1);
                                reg_read    <= 1'b1;
                                state_q     <= RD_STROBE;
                            end
                        end
                    end
                    FINISH: begin
                        reg_addrvalid <= 1'b0;
                        done          <= 1'b1;
                        state_q       <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cw305_reg_bus_master.sv
`default_nettype none
// ============================================================================
// tb_cw305_reg_bus_master : randomized bench with a strobe-level bus model.
// Revision: 1.0
// ============================================================================
module tb_cw305_reg_bus_master;

    localparam int AW = 13;
    localparam int BW = 8;

    logic          usb_clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [BW-1:0] cmd_last = '0;
    logic          wr_valid = 1'b0, rd_ready = 1'b0, abort_i = 1'b0;
    logic [7:0]    wr_data = '0;
    logic [7:0]    read_data = '0;
    logic          cmd_ready, wr_ready, rd_valid, busy, done, aborted;
    logic [7:0]    rd_data, write_data;
    logic [AW-1:0] reg_address;
    logic [BW-1:0] reg_bytecnt;
    logic          reg_read, reg_write, reg_addrvalid;

    cw305_reg_bus_master #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(8)) dut (
        .usb_clk(usb_clk), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_last(cmd_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .abort_i(abort_i), .busy(busy), .done(done), .aborted(aborted),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .write_data(write_data), .read_data(read_data),
        .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid)
    );

    always #5 usb_clk = ~usb_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Register-slave model: read data depends only on the byte index.
    always @(posedge usb_clk) if (reg_read) read_data <= reg_bytecnt ^ 8'h5A;

    int          cyc = 0;
    logic [28:0] wq[$];
    logic [20:0] rq[$];
    int          wcyc[$];
    int          done_cnt = 0;

    always @(posedge usb_clk) cyc++;

    always @(negedge usb_clk) begin
        if (!reset_i) begin
            if (reg_write) begin
                wq.push_back({reg_address, reg_bytecnt, write_data});
                wcyc.push_back(cyc);
            end
            if (reg_read) rq.push_back({reg_address, reg_bytecnt});
            if (reg_read || reg_write) check("strobe_qual", {reg_addrvalid, reg_read & reg_write}, 2'b10);
            if (done) done_cnt++;
        end
    end

    logic [7:0] exp_b[256];

    task automatic start_cmd(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] l);
        int t = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_last = l;
        while (!cmd_ready && t < 100) begin @(negedge usb_clk); t++; end
        if (t >= 100) check("cmd_accept_timeout", 0, 1);
        @(negedge usb_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input logic exp_abort);
        int t = 0;
        while (!done && t < 3000) begin @(negedge usb_clk); t++; end
        check("done_seen", done, 1);
        check("done_aborted", aborted, exp_abort);
        @(negedge usb_clk);
    endtask

    task automatic write_bytes(input int n, input int gapmax);
        int t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gapmax, 0)) @(negedge usb_clk);
            wr_valid = 1'b1; wr_data = exp_b[i];
            t = 0;
            while (!wr_ready && t < 200) begin @(negedge usb_clk); t++; end
            if (t >= 200) begin check("wr_ready_timeout", 0, 1); wr_valid = 1'b0; return; end
            @(negedge usb_clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic run_write(input logic [AW-1:0] a, input int l, input int gapmax, input logic chk_space);
        int d0 = done_cnt;
        int n;
        wq.delete(); wcyc.delete();
        for (int i = 0; i <= l; i++) exp_b[i] = 8'($urandom);
        start_cmd(1'b1, a, BW'(l));
        write_bytes(l + 1, gapmax);
        wait_done(1'b0);
        check("wr_done_once", done_cnt - d0, 1);
        check("wr_strobe_count", wq.size(), l + 1);
        n = (wq.size() < l + 1) ? wq.size() : l + 1;
        for (int i = 0; i < n; i++) check("wr_strobe", wq[i], {a, i[7:0], exp_b[i]});
        if (chk_space)
            for (int i = 1; i < n; i++) check("wr_spacing", wcyc[i] - wcyc[i-1], 2);
        check("wr_av_after", {reg_addrvalid, busy, cmd_ready}, 3'b001);
    endtask

    task automatic run_read(input logic [AW-1:0] a, input int l, input int hmin, input int hmax);
        int t;
        int d0 = done_cnt;
        logic [7:0] e;
        rq.delete();
        start_cmd(1'b0, a, BW'(l));
        for (int i = 0; i <= l; i++) begin
            e = 8'(i) ^ 8'h5A;
            t = 0;
            while (!rd_valid && t < 100) begin @(negedge usb_clk); t++; end
            if (t >= 100) begin check("rd_valid_timeout", 0, 1); return; end
            check("rd_data", rd_data, e);
            repeat ($urandom_range(hmax, hmin)) begin
                @(negedge usb_clk);
                check("rd_hold", {rd_valid, rd_data}, {1'b1, e});
                check("rd_no_extra", rq.size(), i + 1);
            end
            rd_ready = 1'b1;
            @(negedge usb_clk);
            rd_ready = 1'b0;
        end
        wait_done(1'b0);
        check("rd_done_once", done_cnt - d0, 1);
        check("rd_strobe_count", rq.size(), l + 1);
        for (int i = 0; i < rq.size() && i <= l; i++) check("rd_strobe", rq[i], {a, i[7:0]});
        check("rd_av_after", reg_addrvalid, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) @(negedge usb_clk);
        check("rst_outputs", {reg_read, reg_write, reg_addrvalid, rd_valid, done, aborted, busy}, 7'b0);
        check("rst_data", {reg_address, reg_bytecnt, write_data, rd_data}, 37'b0);
        reset_i = 1'b0;
        @(negedge usb_clk);
        check("post_rst_ready", {cmd_ready, busy, wr_ready}, 3'b100);

        // Back-to-back write of A0..A3.
        exp_b[0] = 8'hA0;
        wq.delete(); wcyc.delete();
        begin
            int d0 = done_cnt;
            for (int i = 0; i < 4; i++) exp_b[i] = 8'hA0 + 8'(i);
            start_cmd(1'b1, 13'h05, 8'd3);
            write_bytes(4, 0);
            wait_done(1'b0);
            check("wa_done_once", done_cnt - d0, 1);
            check("wa_count", wq.size(), 4);
            for (int i = 0; i < 4 && i < wq.size(); i++) check("wa_strobe", wq[i], {13'h05, i[7:0], 8'hA0 + 8'(i)});
            for (int i = 1; i < 4 && i < wcyc.size(); i++) check("wa_spacing", wcyc[i] - wcyc[i-1], 2);
        end

        run_read(13'h06, 15, 0, 0);
        run_read(13'h0A1, 3, 10, 10);
        run_write(13'h1F00, 255, 7, 1'b0);

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(1, 0) == 1) run_write(AW'($urandom), $urandom_range(20, 0), $urandom_range(3, 0), 1'b0);
            else run_read(AW'($urandom), $urandom_range(20, 0), 0, 4);
        end

        // Abort while holding byte 2 of an 8-byte read.
        rq.delete();
        start_cmd(1'b0, 13'h0123, 8'd7);
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (!rd_valid && t < 100) begin @(negedge usb_clk); t++; end
            if (t >= 100) check("ab_rd_timeout", 0, 1);
            if (i < 2) begin rd_ready = 1'b1; @(negedge usb_clk); rd_ready = 1'b0; end
        end
        abort_i = 1'b1;
        @(negedge usb_clk);
        abort_i = 1'b0;
        check("ab_flags", {done, aborted, reg_addrvalid, rd_valid, busy, cmd_ready}, 6'b110001);
        check("ab_reads", rq.size(), 3);
        repeat (4) @(negedge usb_clk);
        check("ab_no_more_reads", rq.size(), 3);
        run_write(13'h0042, 2, 1, 1'b0);

        // Asynchronous reset while a write strobe is high.
        for (int i = 0; i < 10; i++) exp_b[i] = 8'($urandom);
        start_cmd(1'b1, 13'h01AB, 8'd9);
        write_bytes(1, 0);
        wr_valid = 1'b1; wr_data = 8'h3C;
        t = 0;
        while (!wr_ready && t < 100) begin @(negedge usb_clk); t++; end
        @(negedge usb_clk);
        wr_valid = 1'b0;
        check("rs_strobe_before", reg_write, 1);
        #2 reset_i = 1'b1;
        #1;
        check("rs_async_zero", {reg_write, reg_read, reg_addrvalid, busy, done, rd_valid}, 6'b0);
        check("rs_async_data", {reg_address, reg_bytecnt, write_data}, 29'b0);
        @(negedge usb_clk);
        reset_i = 1'b0;
        t = done_cnt;
        repeat (3) @(negedge usb_clk);
        check("rs_after", {cmd_ready, busy, done}, 3'b100);
        check("rs_no_done", done_cnt, t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
